// File: rtl/hot_page_mig_dispatcher.sv
// Captures a group of page-pair migrations, issues one copy command per live pair and
// retires the group once every issued copy completes. Macro HPPB_MIG_ERR_CNT_EN adds the error counter.
module hot_page_mig_dispatcher #(
  parameter int MIG_GRP_SIZE = 16,
  parameter int PAGE_SHIFT   = 12
) (
  input  logic                            axi4_mm_clk,
  input  logic                            axi4_mm_rst_n,
  input  logic                            new_addr_available,
  input  logic [MIG_GRP_SIZE*64-1:0]      grp_src_addr,
  input  logic [MIG_GRP_SIZE*64-1:0]      grp_dst_addr,
  output logic                            cpy_req_valid,
  input  logic                            cpy_req_ready,
  output logic [63:0]                     cpy_req_src,
  output logic [63:0]                     cpy_req_dst,
  output logic [$clog2(MIG_GRP_SIZE)-1:0] cpy_req_id,
  input  logic                            cpy_done_valid,
  input  logic [$clog2(MIG_GRP_SIZE)-1:0] cpy_done_id,
  input  logic                            cpy_done_err,
  output logic [63:0]                     mig_done_cnt,
  output logic                            busy,
  output logic [31:0]                     grp_drop_cnt,
  output logic [31:0]                     csr_mig_err_cnt
);

  localparam int N   = MIG_GRP_SIZE;
  localparam int IDW = $clog2(MIG_GRP_SIZE);
  localparam logic [63:0]  PAGE_MASK = ~((64'd1 << PAGE_SHIFT) - 64'd1);
  localparam logic [N-1:0] ONE_BIT   = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         r_state;
  logic           r_busy;
  logic           r_req_valid;
  logic [63:0]    r_req_src;
  logic [63:0]    r_req_dst;
  logic [IDW-1:0] r_req_id;
  logic [63:0]    r_done_cnt;
  logic [31:0]    r_drop_cnt;
  logic [N-1:0]   r_pend;
  logic [N-1:0]   r_out;
  logic [63:0]    r_src [N];
  logic [63:0]    r_dst [N];

  logic           w_capture;
  logic           w_accept;
  logic [N-1:0]   w_cap_pend;
  logic [N-1:0]   w_acc_vec;
  logic [N-1:0]   w_done_vec;
  logic [N-1:0]   w_out_next;
  logic [N-1:0]   w_pend_next;
  logic [N-1:0]   w_sel_vec;
  logic           w_sel_any;
  logic [IDW-1:0] w_sel_idx;
  logic [63:0]    w_sel_src;
  logic [63:0]    w_sel_dst;

  assign w_capture   = (r_state == IDLE) && new_addr_available;
  assign w_accept    = r_req_valid && cpy_req_ready;
  assign w_acc_vec   = w_accept ? (ONE_BIT << r_req_id) : '0;
  assign w_done_vec  = cpy_done_valid ? (ONE_BIT << cpy_done_id) : '0;
  assign w_out_next  = (r_out | w_acc_vec) & ~w_done_vec;
  assign w_pend_next = r_pend & ~w_acc_vec;
  assign w_sel_vec   = (r_state == IDLE) ? w_cap_pend : w_pend_next;

  always_comb begin
    w_cap_pend = '0;
    for (int k = 0; k < N; k++) begin
      w_cap_pend[k] = (grp_src_addr[64*k+PAGE_SHIFT +: 64-PAGE_SHIFT] != '0) &&
                      (grp_dst_addr[64*k+PAGE_SHIFT +: 64-PAGE_SHIFT] != '0);
    end
  end

  // Scanning downward leaves the lowest pending pair selected, so the next command
  // can be loaded on the same edge that retires the current one.
  always_comb begin
    w_sel_any = 1'b0;
    w_sel_idx = '0;
    w_sel_src = '0;
    w_sel_dst = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_sel_vec[k]) begin
        w_sel_any = 1'b1;
        w_sel_idx = IDW'(k);
        w_sel_src = (r_state == IDLE) ? grp_src_addr[64*k +: 64] : r_src[k];
        w_sel_dst = (r_state == IDLE) ? grp_dst_addr[64*k +: 64] : r_dst[k];
      end
    end
  end

  always_ff @(posedge axi4_mm_clk) begin
    if (w_capture) begin
      for (int k = 0; k < N; k++) begin
        r_src[k] <= grp_src_addr[64*k +: 64];
        r_dst[k] <= grp_dst_addr[64*k +: 64];
      end
    end
  end

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_src   <= '0;
      r_req_dst   <= '0;
      r_req_id    <= '0;
      r_done_cnt  <= '0;
      r_drop_cnt  <= '0;
      r_pend      <= '0;
      r_out       <= '0;
    end else begin
      r_out <= w_out_next;
      if (new_addr_available && (r_state != IDLE) && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + 32'd1;
      case (r_state)
        IDLE: begin
          if (new_addr_available) begin
            r_busy <= 1'b1;
            r_pend <= w_cap_pend;
            if (w_sel_any) begin
              r_req_valid <= 1'b1;
              r_req_id    <= w_sel_idx;
              r_req_src   <= w_sel_src & PAGE_MASK;
              r_req_dst   <= w_sel_dst & PAGE_MASK;
              r_state     <= ISSUE;
            end else begin
              r_state <= DONE;
            end
          end
        end
        ISSUE: begin
          if (w_accept) begin
            r_pend <= w_pend_next;
            if (w_sel_any) begin
              r_req_id  <= w_sel_idx;
              r_req_src <= w_sel_src & PAGE_MASK;
              r_req_dst <= w_sel_dst & PAGE_MASK;
            end else begin
              r_req_valid <= 1'b0;
              r_state     <= (w_out_next == '0) ? DONE : WAIT;
            end
          end
        end
        WAIT: begin
          if (w_out_next == '0)
            r_state <= DONE;
        end
        DONE: begin
          r_done_cnt <= r_done_cnt + 64'd1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpy_req_valid = r_req_valid;
  assign cpy_req_src   = r_req_src;
  assign cpy_req_dst   = r_req_dst;
  assign cpy_req_id    = r_req_id;
  assign mig_done_cnt  = r_done_cnt;
  assign busy          = r_busy;
  assign grp_drop_cnt  = r_drop_cnt;

`ifdef HPPB_MIG_ERR_CNT_EN
  logic [31:0] r_err_cnt;

  // Every errored completion counts, even one for an id that is not outstanding.
  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n)
      r_err_cnt <= '0;
    else if (cpy_done_valid && cpy_done_err && (r_err_cnt != '1))
      r_err_cnt <= r_err_cnt + 32'd1;
  end

  assign csr_mig_err_cnt = r_err_cnt;
`else
  logic w_unused_err;

  assign w_unused_err    = cpy_done_err;
  assign csr_mig_err_cnt = '0;
`endif

endmodule

// File: tb/tb_hot_page_mig_dispatcher.sv
// Directed bench for hot_page_mig_dispatcher; a cycle-stepped copy-engine model drives
// ready/completions while each scenario task checks the results it expects.
module tb_hot_page_mig_dispatcher;

  localparam int N  = 16;
  localparam int PS = 12;

`ifdef HPPB_MIG_ERR_CNT_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  logic            axi4_mm_clk = 1'b0;
  logic            axi4_mm_rst_n = 1'b1;
  logic            new_addr_available = 1'b0;
  logic [N*64-1:0] grp_src_addr = '0;
  logic [N*64-1:0] grp_dst_addr = '0;
  logic            cpy_req_valid;
  logic            cpy_req_ready = 1'b0;
  logic [63:0]     cpy_req_src;
  logic [63:0]     cpy_req_dst;
  logic [3:0]      cpy_req_id;
  logic            cpy_done_valid = 1'b0;
  logic [3:0]      cpy_done_id = '0;
  logic            cpy_done_err = 1'b0;
  logic [63:0]     mig_done_cnt;
  logic            busy;
  logic [31:0]     grp_drop_cnt;
  logic [31:0]     csr_mig_err_cnt;

  int checks = 0;
  int failures = 0;
  int accIds[$];
  int accCycles[$];
  int engPayloadBad;
  int engOrderBad;
  int engTimedOut;
  logic [15:0] curSkip;

  hot_page_mig_dispatcher #(.MIG_GRP_SIZE(N), .PAGE_SHIFT(PS)) dut (
    .axi4_mm_clk(axi4_mm_clk), .axi4_mm_rst_n(axi4_mm_rst_n),
    .new_addr_available(new_addr_available),
    .grp_src_addr(grp_src_addr), .grp_dst_addr(grp_dst_addr),
    .cpy_req_valid(cpy_req_valid), .cpy_req_ready(cpy_req_ready),
    .cpy_req_src(cpy_req_src), .cpy_req_dst(cpy_req_dst), .cpy_req_id(cpy_req_id),
    .cpy_done_valid(cpy_done_valid), .cpy_done_id(cpy_done_id), .cpy_done_err(cpy_done_err),
    .mig_done_cnt(mig_done_cnt), .busy(busy),
    .grp_drop_cnt(grp_drop_cnt), .csr_mig_err_cnt(csr_mig_err_cnt)
  );

  always #5 axi4_mm_clk = ~axi4_mm_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] expSrc(input int k);
    return 64'h1_0000_0000 + (64'(k + 1) << PS);
  endfunction

  function automatic logic [63:0] expDst(input int k);
    return 64'h2_0000_0000 + (64'(k + 1) << PS);
  endfunction

  task automatic doReset();
    new_addr_available = 1'b0;
    cpy_req_ready = 1'b0;
    cpy_done_valid = 1'b0;
    cpy_done_err = 1'b0;
    #1 axi4_mm_rst_n = 1'b0;
    repeat (2) @(posedge axi4_mm_clk);
    #1 axi4_mm_rst_n = 1'b1;
    @(posedge axi4_mm_clk);
    #1;
  endtask

  // Skipped pairs rotate between src=0, src inside page 0 and dst=0.
  task automatic applyStimulus(input logic [15:0] skipMask);
    for (int k = 0; k < N; k++) begin
      grp_src_addr[64*k +: 64] = expSrc(k);
      grp_dst_addr[64*k +: 64] = expDst(k);
      if (skipMask[k]) begin
        if (k % 3 == 0) grp_src_addr[64*k +: 64] = 64'h0;
        else if (k % 3 == 1) grp_src_addr[64*k +: 64] = 64'hABC;
        else grp_dst_addr[64*k +: 64] = 64'h0;
      end
    end
    curSkip = skipMask;
    new_addr_available = 1'b1;
    @(posedge axi4_mm_clk);
    #1 new_addr_available = 1'b0;
  endtask

  // complMode 0: done 2 cycles after accept; 1: all done in reverse order after the last accept; 2: none.
  task automatic runEngine(input int readyMode, input int complMode, input int errId,
                           input int pulseAt, input int maxCycles);
    int doneAt[N];
    int expCount;
    int revIdx;
    int lastId;
    for (int k = 0; k < N; k++) doneAt[k] = -1;
    accIds.delete();
    accCycles.delete();
    engPayloadBad = 0;
    engOrderBad = 0;
    engTimedOut = 1;
    lastId = -1;
    revIdx = -1;
    expCount = N - $countones(curSkip);
    for (int cyc = 0; cyc < maxCycles; cyc++) begin
      if (busy !== 1'b1) begin
        engTimedOut = 0;
        break;
      end
      cpy_req_ready = (readyMode == 0) ? 1'b1 : (cyc % 2 == 0);
      new_addr_available = (cyc == pulseAt);
      cpy_done_valid = 1'b0;
      cpy_done_err = 1'b0;
      if (complMode == 0) begin
        for (int k = 0; k < N; k++) begin
          if (!cpy_done_valid && doneAt[k] >= 0 && doneAt[k] <= cyc) begin
            cpy_done_valid = 1'b1;
            cpy_done_id = 4'(k);
            cpy_done_err = (k == errId);
            doneAt[k] = -1;
          end
        end
      end else if (complMode == 1 && revIdx >= 0) begin
        cpy_done_valid = 1'b1;
        cpy_done_id = 4'(accIds[revIdx]);
        cpy_done_err = (accIds[revIdx] == errId);
        revIdx--;
      end
      if (cpy_req_valid && cpy_req_ready) begin
        if (int'(cpy_req_id) <= lastId) engOrderBad++;
        lastId = int'(cpy_req_id);
        if (cpy_req_src !== expSrc(lastId) || cpy_req_dst !== expDst(lastId)) engPayloadBad++;
        accIds.push_back(lastId);
        accCycles.push_back(cyc);
        doneAt[lastId] = cyc + 2;
        if (complMode == 1 && accIds.size() == expCount) revIdx = expCount - 1;
      end
      @(posedge axi4_mm_clk);
      #1;
    end
    cpy_req_ready = 1'b0;
    cpy_done_valid = 1'b0;
    cpy_done_err = 1'b0;
    new_addr_available = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %0b expected 0", busy); end
    checks++;
    if (cpy_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %0b expected 0", cpy_req_valid); end
    checks++;
    if (cpy_req_src !== 64'h0 || cpy_req_dst !== 64'h0 || cpy_req_id !== 4'h0) begin
      failures++; $display("[TB] FAIL rst_payload: got src=%h dst=%h id=%0d expected zeros", cpy_req_src, cpy_req_dst, cpy_req_id);
    end
    checks++;
    if (mig_done_cnt !== 64'd0 || grp_drop_cnt !== 32'd0 || csr_mig_err_cnt !== 32'd0) begin
      failures++; $display("[TB] FAIL rst_counters: got done=%0d drop=%0d err=%0d expected 0/0/0", mig_done_cnt, grp_drop_cnt, csr_mig_err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    doReset();
    applyStimulus(16'h0000);
    checks++;
    if (busy !== 1'b1 || cpy_req_valid !== 1'b1 || mig_done_cnt !== 64'd0) begin
      failures++; $display("[TB] FAIL b2b_start: got busy=%0b valid=%0b done=%0d expected 1/1/0", busy, cpy_req_valid, mig_done_cnt);
    end
    runEngine(0, 0, -1, -1, 60);
    bad = 0;
    for (int i = 0; i < accIds.size(); i++) if (accIds[i] != i || accCycles[i] != i) bad++;
    checks++;
    if (accIds.size() != 16 || bad != 0) begin
      failures++; $display("[TB] FAIL b2b_sequence: got %0d accepts with %0d out of place expected 16 with 0", accIds.size(), bad);
    end
    checks++;
    if (engPayloadBad != 0) begin failures++; $display("[TB] FAIL b2b_payload: got %0d bad payloads expected 0", engPayloadBad); end
    checks++;
    if (engTimedOut != 0 || mig_done_cnt !== 64'd1 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_done: got timeout=%0d done=%0d busy=%0b expected 0/1/0", engTimedOut, mig_done_cnt, busy);
    end
  endtask

  task automatic test_skip_pairs();
    int expIds[$];
    int bad;
    doReset();
    applyStimulus(16'h0208);
    runEngine(0, 0, -1, -1, 60);
    for (int k = 0; k < N; k++) if (k != 3 && k != 9) expIds.push_back(k);
    bad = 0;
    for (int i = 0; i < accIds.size() && i < expIds.size(); i++)
      if (accIds[i] != expIds[i] || accCycles[i] != i) bad++;
    checks++;
    if (accIds.size() != 14 || bad != 0) begin
      failures++; $display("[TB] FAIL skip_sequence: got %0d accepts with %0d out of place expected 14 with 0", accIds.size(), bad);
    end
    checks++;
    if (engPayloadBad != 0) begin failures++; $display("[TB] FAIL skip_payload: got %0d bad payloads expected 0", engPayloadBad); end
    checks++;
    if (engTimedOut != 0 || mig_done_cnt !== 64'd1) begin
      failures++; $display("[TB] FAIL skip_done: got timeout=%0d done=%0d expected 0/1", engTimedOut, mig_done_cnt);
    end
  endtask

  task automatic test_all_skipped();
    int validSeen;
    doReset();
    applyStimulus(16'hFFFF);
    validSeen = cpy_req_valid ? 1 : 0;
    checks++;
    if (busy !== 1'b1 || mig_done_cnt !== 64'd0) begin
      failures++; $display("[TB] FAIL allskip_done_state: got busy=%0b done=%0d expected 1/0", busy, mig_done_cnt);
    end
    @(posedge axi4_mm_clk);
    #1;
    validSeen += cpy_req_valid ? 1 : 0;
    checks++;
    if (busy !== 1'b0 || mig_done_cnt !== 64'd1) begin
      failures++; $display("[TB] FAIL allskip_idle: got busy=%0b done=%0d expected 0/1", busy, mig_done_cnt);
    end
    @(posedge axi4_mm_clk);
    #1;
    validSeen += cpy_req_valid ? 1 : 0;
    checks++;
    if (validSeen != 0 || busy !== 1'b0 || mig_done_cnt !== 64'd1) begin
      failures++; $display("[TB] FAIL allskip_quiet: got valid_cycles=%0d busy=%0b done=%0d expected 0/0/1", validSeen, busy, mig_done_cnt);
    end
  endtask

  task automatic test_drop_while_busy();
    int busySeen;
    doReset();
    applyStimulus(16'h0000);
    runEngine(0, 0, -1, 16, 60);
    checks++;
    if (grp_drop_cnt !== 32'd1) begin failures++; $display("[TB] FAIL drop_cnt: got %0d expected 1", grp_drop_cnt); end
    checks++;
    if (engTimedOut != 0 || accIds.size() != 16 || mig_done_cnt !== 64'd1) begin
      failures++; $display("[TB] FAIL drop_first_group: got timeout=%0d accepts=%0d done=%0d expected 0/16/1", engTimedOut, accIds.size(), mig_done_cnt);
    end
    busySeen = 0;
    repeat (3) begin
      @(posedge axi4_mm_clk);
      #1;
      busySeen += (busy || cpy_req_valid) ? 1 : 0;
    end
    checks++;
    if (busySeen != 0 || mig_done_cnt !== 64'd1) begin
      failures++; $display("[TB] FAIL drop_no_restart: got active_cycles=%0d done=%0d expected 0/1", busySeen, mig_done_cnt);
    end
  endtask

  task automatic test_reverse_errors();
    doReset();
    applyStimulus(16'h0000);
    runEngine(1, 1, 7, -1, 120);
    checks++;
    if (accIds.size() != 16 || engOrderBad != 0 || engPayloadBad != 0) begin
      failures++; $display("[TB] FAIL rev_issue: got accepts=%0d order_bad=%0d payload_bad=%0d expected 16/0/0", accIds.size(), engOrderBad, engPayloadBad);
    end
    checks++;
    if (engTimedOut != 0 || mig_done_cnt !== 64'd1) begin
      failures++; $display("[TB] FAIL rev_done: got timeout=%0d done=%0d expected 0/1", engTimedOut, mig_done_cnt);
    end
    checks++;
    if (csr_mig_err_cnt !== EXP_ERR) begin
      failures++; $display("[TB] FAIL rev_err_cnt: got %0d expected %0d", csr_mig_err_cnt, EXP_ERR);
    end
  endtask

  // Starts from the previous group's counters so the reset has something to clear.
  task automatic test_reset_mid_group();
    int active;
    checks++;
    if (mig_done_cnt !== 64'd1) begin failures++; $display("[TB] FAIL mid_pre_cnt: got %0d expected 1", mig_done_cnt); end
    applyStimulus(16'hFFE0);
    runEngine(0, 2, -1, -1, 10);
    checks++;
    if (busy !== 1'b1 || accIds.size() != 5 || cpy_req_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_wait: got busy=%0b accepts=%0d valid=%0b expected 1/5/0", busy, accIds.size(), cpy_req_valid);
    end
    axi4_mm_rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || cpy_req_valid !== 1'b0 || cpy_req_src !== 64'h0 || cpy_req_dst !== 64'h0 || cpy_req_id !== 4'h0) begin
      failures++; $display("[TB] FAIL mid_rst_outputs: got busy=%0b valid=%0b src=%h dst=%h id=%0d expected zeros", busy, cpy_req_valid, cpy_req_src, cpy_req_dst, cpy_req_id);
    end
    checks++;
    if (mig_done_cnt !== 64'd0 || grp_drop_cnt !== 32'd0 || csr_mig_err_cnt !== 32'd0) begin
      failures++; $display("[TB] FAIL mid_rst_counters: got done=%0d drop=%0d err=%0d expected 0/0/0", mig_done_cnt, grp_drop_cnt, csr_mig_err_cnt);
    end
    @(posedge axi4_mm_clk);
    #1 axi4_mm_rst_n = 1'b1;
    active = 0;
    for (int i = 0; i < 5; i++) begin
      cpy_done_valid = 1'b1;
      cpy_done_id = 4'(i);
      @(posedge axi4_mm_clk);
      #1;
      active += (busy || cpy_req_valid) ? 1 : 0;
    end
    cpy_done_valid = 1'b0;
    checks++;
    if (active != 0 || mig_done_cnt !== 64'd0) begin
      failures++; $display("[TB] FAIL mid_late_done: got active_cycles=%0d done=%0d expected 0/0", active, mig_done_cnt);
    end
    applyStimulus(16'h0000);
    runEngine(0, 0, -1, -1, 60);
    checks++;
    if (engTimedOut != 0 || accIds.size() != 16 || mig_done_cnt !== 64'd1) begin
      failures++; $display("[TB] FAIL mid_next_group: got timeout=%0d accepts=%0d done=%0d expected 0/16/1", engTimedOut, accIds.size(), mig_done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_skip_pairs();
    test_all_skipped();
    test_drop_while_busy();
    test_reverse_errors();
    test_reset_mid_group();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
